// File: rtl/pulse_sched_pkg.sv
// Shared constants for the pulse scheduler: FSM state encoding and default field width.
package pulse_sched_pkg;

  localparam int unsigned CNT_W_DEFAULT = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DELAY = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

endpackage

// File: rtl/sched_down_counter.sv
// Loadable down-counter that saturates at zero and flags when it has reached zero.
module sched_down_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_value,
  output logic         zero_c
);

  logic [W-1:0] value;

  // load wins over dec; dec at zero holds so the count never wraps
  always_ff @(posedge clock) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (dec && (value != '0)) begin
      value <= value - W'(1);
    end
  end

  assign zero_c = (value == '0);

endmodule

// File: rtl/pulse_scheduler.sv
// Programmable delayed pulse-train generator: after start, waits delay cycles then emits
// count pulses of width high / gap low cycles, with busy and a one-cycle done strobe.
module pulse_scheduler
  import pulse_sched_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] gap,
  input  logic [CNT_W-1:0] count,
  output logic             signal,
  output logic             busy,
  output logic             done
);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] width_q, gap_q;
  logic             latch;

  logic             timer_load, timer_dec, timer_zero;
  logic [CNT_W-1:0] timer_value;
  logic             pulse_load, pulse_dec, pulse_zero;
  logic [CNT_W-1:0] pulse_value;

  // Phase timer holds remaining cycles of the current DELAY/HIGH/LOW phase
  sched_down_counter #(.W(CNT_W)) u_phase_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .dec        (timer_dec),
    .load_value (timer_value),
    .zero_c     (timer_zero)
  );

  // Pulse counter holds pulses remaining after the current one
  sched_down_counter #(.W(CNT_W)) u_pulse_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (pulse_load),
    .dec        (pulse_dec),
    .load_value (pulse_value),
    .zero_c     (pulse_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Phase lengths are latched at start and clamped to at least one cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      width_q <= '0;
      gap_q   <= '0;
    end else if (latch) begin
      width_q <= (width == '0) ? CNT_W'(1) : width;
      gap_q   <= (gap == '0) ? CNT_W'(1) : gap;
    end
  end

  always_comb begin
    state_d     = state_q;
    latch       = 1'b0;
    timer_load  = 1'b0;
    timer_dec   = 1'b0;
    timer_value = '0;
    pulse_load  = 1'b0;
    pulse_dec   = 1'b0;
    pulse_value = '0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          latch = 1'b1;
          if (count == '0) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_DELAY;
            timer_load  = 1'b1;
            timer_value = delay;
            pulse_load  = 1'b1;
            pulse_value = count - CNT_W'(1);
          end
        end
      end
      S_DELAY: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (timer_zero) begin
          state_d     = S_HIGH;
          timer_load  = 1'b1;
          timer_value = width_q - CNT_W'(1);
        end else begin
          timer_dec = 1'b1;
        end
      end
      S_HIGH: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (timer_zero) begin
          if (pulse_zero) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_LOW;
            pulse_dec   = 1'b1;
            timer_load  = 1'b1;
            timer_value = gap_q - CNT_W'(1);
          end
        end else begin
          timer_dec = 1'b1;
        end
      end
      S_LOW: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (timer_zero) begin
          state_d     = S_HIGH;
          timer_load  = 1'b1;
          timer_value = width_q - CNT_W'(1);
        end else begin
          timer_dec = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode the current state one cycle later; abort clears them at its own edge
  always_ff @(posedge clock) begin
    if (reset) begin
      signal <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      signal <= (state_q == S_HIGH) && !abort;
      busy   <= ((state_q == S_DELAY) || (state_q == S_HIGH) || (state_q == S_LOW)) && !abort;
      done   <= (state_q == S_DONE);
    end
  end

endmodule

// File: doc/pulse_scheduler.md
Name: pulse_scheduler

Overview:
Synthesizable, programmable replacement for the bench-only pulse/trigger generators. On an arm request it waits a programmed delay and then emits a train of `count` pulses with programmed high and low widths. It reports busy and done, and sits between control logic and any block that needs timed strobes. All timing is in clock cycles; there are no `#` delays.

Parameters:
CNT_W, 8, width of the delay, width, gap and count fields and of the internal down-counter.

Ports:
clock    in   1      system clock; all logic on rising edge
reset    in   1      synchronous, active-high reset
start    in   1      arm request; sampled only in IDLE
abort    in   1      cancel the running sequence; sampled in every state
delay    in   CNT_W  cycles between start sample and first pulse
width    in   CNT_W  high cycles per pulse (0 treated as 1)
gap      in   CNT_W  low cycles between pulses (0 treated as 1)
count    in   CNT_W  number of pulses (0 means no pulses)
signal   out  1      registered pulse output
busy     out  1      high while a sequence is in progress (DELAY/HIGH/LOW)
done     out  1      one-cycle completion strobe

Behaviour:
- Reset, sampled at the clock edge:
  - state=IDLE, signal=0, busy=0, done=0, all counters=0.
  - Reset has priority over abort and start.
  - Reset mid-sequence: outputs are 0 from the next cycle; done is not pulsed.
- All outputs are registered and decoded from state.
- States: IDLE, DELAY, HIGH, LOW, DONE.
- Parameter latching:
  - delay, width, gap and count are latched on the edge where start is accepted.
  - Input changes during a sequence have no effect.
  - Stored width and gap are clamped to a minimum of 1.
- IDLE:
  - start=1 at edge k with count≠0: go to DELAY, load the counter with delay, busy=1 from cycle k+1.
  - start=1 with count=0: go straight to DONE.
- DELAY:
  - Counter decrements each cycle.
  - When the counter is 0, go to HIGH.
  - With delay=0, DELAY lasts exactly one cycle.
  - First signal-high cycle is cycle k+1+delay+1, i.e. latency from start sample to rise is delay+2 edges (fixed, documented).
- HIGH:
  - signal=1 for exactly width cycles.
  - Decrement the remaining pulse count on exit.
  - If pulses remain, go to LOW; otherwise go to DONE.
- LOW:
  - signal=0 for exactly gap cycles, then go to HIGH.
  - Period = width+gap cycles.
- DONE:
  - done=1, busy=0, signal=0 for exactly one cycle, then IDLE.
  - A new start can be accepted in the cycle after DONE (IDLE).
  - start asserted while in DONE is ignored.
- abort:
  - In DELAY, HIGH or LOW: next state is IDLE; signal=0 and busy=0 the next cycle; no done strobe.
  - In IDLE or DONE: ignored.
  - abort and start asserted together in IDLE: abort wins and start is ignored.
- start held high:
  - Ignored while busy.
  - If still high in IDLE after DONE, a new sequence starts (re-trigger; no edge detect).
- Counters:
  - Unsigned, CNT_W bits, no wrap.
  - Maximum delay, width and gap are 2^CNT_W−1.
  - Maximum count is 2^CNT_W−1 pulses.

Decomposition:
- Package pulse_sched_pkg holds:
  - state encoding localparams: IDLE=0, DELAY=1, HIGH=2, LOW=3, DONE=4, 3-bit;
  - the default CNT_W.
- One sub-module, sched_down_counter: loadable down-counter with load, dec and a zero flag, instantiated twice:
  - phase timer (delay/width/gap);
  - pulse counter.

Test Plan:
1. Reset held during start=1 → signal=0, busy=0, done=0 throughout; after release, stays IDLE until start.
2. delay=3, width=2, gap=1, count=3, start for one cycle at edge k:
   - signal high at cycles k+5..6, k+8..9, k+11..12;
   - done=1 at k+13 only;
   - busy=1 for k+1..k+12.
3. width=0, gap=0, delay=0, count=2 → rise at k+2; pattern 1,0,1; done at k+5.
4. count=0 with start → no signal high; done=1 at cycle k+1; busy never 1.
5. abort asserted in the second HIGH cycle of scenario 2 → signal=0 and busy=0 next cycle; no done; a new start is accepted two cycles later.
6. start held high continuously with delay=0, width=1, count=1:
   - sequences repeat back-to-back;
   - inputs changed mid-sequence take effect only on the next start acceptance.
